inv_sub_byte_mix_column: RTL and testbench

- Decrypt-side counterpart of the encrypt SubByte+MixColumn stage.
- Computes state_out = InvSubBytes(InvMixColumns(state_in)) on a 128-bit AES state. This is the exact inverse of the encrypt stage's MixColumns(SubBytes(x)).
- Column-serial: one 32-bit column per cycle through a single InvMixColumns unit, with four inverse S-box lookups per cycle.
- Sits in the decrypt round datapath between AddRoundKey and InvShiftRows, using valid/ready handshakes on both sides.

---
 rtl/inv_sub_byte_mix_column_pkg.sv | 59 +++++
 rtl/inv_sub_byte_mix_column_if.sv | 21 ++
 rtl/inv_sub_byte_mix_column_word.sv | 19 +
 rtl/inv_sub_byte_mix_column.sv | 114 +++++++++++
 tb/tb_inv_sub_byte_mix_column.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/inv_sub_byte_mix_column_pkg.sv
// Shared AES decrypt-side arithmetic: GF(2^8) multiplies, the inverse S-box table
// and the FSM state encoding for the InvMixColumns/InvSubBytes stage.
package aes_dec_pkg;

   localparam logic [7:0]  AES_POLY     = 8'h1b;
   localparam int unsigned AES_NUM_COLS = 4;
   localparam int unsigned AES_COL_W    = 32;
   localparam int unsigned AES_BYTE_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } ismc_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

endpackage

// File: rtl/inv_sub_byte_mix_column_if.sv
// Upstream and downstream valid/ready handshake plus state buses for the stage.
interface inv_sub_byte_mix_column_if #(
   parameter int unsigned DATA_WIDTH = 128
);
   logic                  ismc_valid_in;
   logic                  ismc_ready_out;
   logic [DATA_WIDTH-1:0] state_in;
   logic                  ismc_valid_out;
   logic                  ismc_ready_in;
   logic [DATA_WIDTH-1:0] state_out;

   modport master (
      output ismc_valid_in, state_in, ismc_ready_in,
      input  ismc_ready_out, ismc_valid_out, state_out
   );

   modport slave (
      input  ismc_valid_in, state_in, ismc_ready_in,
      output ismc_ready_out, ismc_valid_out, state_out
   );
endinterface

// File: rtl/inv_sub_byte_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column (byte 0 in the MSBs).
module inv_mix_column_word
   import aes_dec_pkg::*;
(
   input  logic [AES_COL_W-1:0] col_in,
   output logic [AES_COL_W-1:0] col_out_c
);
   logic [7:0] a0, a1, a2, a3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   assign col_out_c[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
   assign col_out_c[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
   assign col_out_c[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
   assign col_out_c[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
endmodule

// File: rtl/inv_sub_byte_mix_column.sv
// Column-serial InvSubBytes(InvMixColumns(state)) stage for the AES decrypt round,
// one column per cycle, valid/ready on both sides.
module inv_sub_byte_mix_column
   import aes_dec_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned NUM_COLS   = AES_NUM_COLS
) (
   input logic                      clk,
   input logic                      reset_n,
   inv_sub_byte_mix_column_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(NUM_COLS);

   if (DATA_WIDTH != 128) begin : g_bad_width
      $error("inv_sub_byte_mix_column: DATA_WIDTH must be 128");
   end
   if (NUM_COLS != AES_NUM_COLS) begin : g_bad_cols
      $error("inv_sub_byte_mix_column: NUM_COLS must be 4");
   end

   ismc_state_e           state_q, state_d;
   logic [CNT_W-1:0]      col_cnt_q, col_cnt_d;
   logic [DATA_WIDTH-1:0] work_q, work_d;

   logic [AES_COL_W-1:0]  cur_col;
   logic [AES_COL_W-1:0]  imc_col_c;
   logic [AES_COL_W-1:0]  new_col;

   // Pick the column addressed by the counter (column 0 lives in the MSBs).
   always_comb begin
      cur_col = '0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
         if (col_cnt_q == CNT_W'(c)) begin
            cur_col = work_q[DATA_WIDTH-1-c*AES_COL_W -: AES_COL_W];
         end
      end
   end

   inv_mix_column_word u_imc (
      .col_in    (cur_col),
      .col_out_c (imc_col_c)
   );

   always_comb begin
      new_col = '0;
      for (int unsigned b = 0; b < AES_COL_W / AES_BYTE_W; b++) begin
         new_col[b*AES_BYTE_W +: AES_BYTE_W] = inv_sbox(imc_col_c[b*AES_BYTE_W +: AES_BYTE_W]);
      end
   end

   // Next-state, counter and working-register update.
   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      work_d    = work_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.ismc_valid_in) begin
               work_d    = bus.state_in;
               col_cnt_d = '0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
               if (col_cnt_q == CNT_W'(c)) begin
                  work_d[DATA_WIDTH-1-c*AES_COL_W -: AES_COL_W] = new_col;
               end
            end
            if (col_cnt_q == CNT_W'(NUM_COLS - 1)) begin
               col_cnt_d = '0;
               state_d   = ST_DONE;
            end else begin
               col_cnt_d = col_cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.ismc_ready_in) begin
               if (bus.ismc_valid_in) begin
                  work_d    = bus.state_in;
                  col_cnt_d = '0;
                  state_d   = ST_BUSY;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            col_cnt_d = '0;
            work_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         col_cnt_q <= '0;
         work_q    <= '0;
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         work_q    <= work_d;
      end
   end

   // Ready passes straight through in DONE so a new state can enter on the consume edge.
   assign bus.ismc_ready_out = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ismc_ready_in);
   assign bus.ismc_valid_out = (state_q == ST_DONE);
   assign bus.state_out      = (state_q == ST_DONE) ? work_q : '0;

endmodule

// File: tb/tb_inv_sub_byte_mix_column.sv
// Directed and round-trip checks for inv_sub_byte_mix_column against an
// independent encrypt-side SubBytes+MixColumns model.
module tb_inv_sub_byte_mix_column;

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   inv_sub_byte_mix_column_if #(.DATA_WIDTH(128)) bus ();

   inv_sub_byte_mix_column #(.DATA_WIDTH(128), .NUM_COLS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [7:0] FWD_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] tb_x2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Encrypt-side MixColumns(SubBytes(x)) reference.
   function automatic logic [127:0] tb_enc(input logic [127:0] x);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = FWD_SBOX[x[127-32*c -: 8]];
         a1 = FWD_SBOX[x[119-32*c -: 8]];
         a2 = FWD_SBOX[x[111-32*c -: 8]];
         a3 = FWD_SBOX[x[103-32*c -: 8]];
         r[127-32*c -: 8] = tb_x2(a0) ^ tb_x2(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ tb_x2(a1) ^ tb_x2(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ tb_x2(a2) ^ tb_x2(a3) ^ a3;
         r[103-32*c -: 8] = tb_x2(a0) ^ a0 ^ a1 ^ a2 ^ tb_x2(a3);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Send one state from IDLE with ready_in high; check latency, result and one-cycle valid.
   task automatic run_state(input string tag, input logic [127:0] din, input logic [127:0] dexp);
      int lat;
      bit seen;
      check({tag, "_rdy"}, 128'(bus.ismc_ready_out), 128'd1);
      bus.ismc_valid_in = 1'b1;
      bus.state_in      = din;
      bus.ismc_ready_in = 1'b1;
      @(posedge clk);
      #1;
      bus.ismc_valid_in = 1'b0;
      bus.state_in      = '0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.ismc_valid_out) seen = 1'b1;
      end
      check({tag, "_valid"}, 128'(bus.ismc_valid_out), 128'd1);
      check({tag, "_lat"}, 128'(lat), 128'd4);
      check({tag, "_data"}, bus.state_out, dexp);
      @(posedge clk);
      #1;
      check({tag, "_vdrop"}, 128'(bus.ismc_valid_out), 128'd0);
      check({tag, "_zero"}, bus.state_out, 128'd0);
   endtask

   localparam logic [127:0] ALL00 = {16{8'h00}};
   localparam logic [127:0] ALL01 = {16{8'h01}};
   localparam logic [127:0] ALL52 = {16{8'h52}};
   localparam logic [127:0] ALL63 = {16{8'h63}};
   localparam logic [127:0] ALL7C = {16{8'h7c}};

   initial begin
      logic [127:0] x;
      logic [127:0] held;
      n_cmp = 0;
      n_err = 0;
      reset_n           = 1'b0;
      bus.ismc_valid_in = 1'b0;
      bus.ismc_ready_in = 1'b0;
      bus.state_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_valid", 128'(bus.ismc_valid_out), 128'd0);
      check("rst_data", bus.state_out, 128'd0);
      check("rst_ready", 128'(bus.ismc_ready_out), 128'd1);

      run_state("zero", ALL00, ALL52);
      run_state("c63", ALL63, ALL00);
      run_state("c7c", ALL7C, ALL01);
      run_state("fips", 128'h046681e5e0cb199a48f8d37a2806264c,
                128'h19f48d08a0c648be9af8e32be93de22a);

      // Backpressure: result held while ready_in is low, then consume+accept on one edge.
      bus.ismc_valid_in = 1'b1;
      bus.state_in      = ALL7C;
      bus.ismc_ready_in = 1'b0;
      @(posedge clk);
      #1;
      bus.ismc_valid_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("bp_valid", 128'(bus.ismc_valid_out), 128'd1);
      held = bus.state_out;
      check("bp_data", held, ALL01);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold", bus.state_out, ALL01);
         check("bp_vhold", 128'(bus.ismc_valid_out), 128'd1);
         check("bp_rdy0", 128'(bus.ismc_ready_out), 128'd0);
      end
      bus.ismc_valid_in = 1'b1;
      bus.state_in      = ALL63;
      bus.ismc_ready_in = 1'b1;
      #1;
      check("bp_rdy_pass", 128'(bus.ismc_ready_out), 128'd1);
      @(posedge clk);
      #1;
      bus.ismc_valid_in = 1'b0;
      bus.state_in      = '0;
      check("bp_consumed", 128'(bus.ismc_valid_out), 128'd0);
      check("bp_busy_rdy", 128'(bus.ismc_ready_out), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      check("bp_early", 128'(bus.ismc_valid_out), 128'd0);
      @(posedge clk);
      #1;
      check("bp_next_valid", 128'(bus.ismc_valid_out), 128'd1);
      check("bp_next_data", bus.state_out, ALL00);
      @(posedge clk);
      #1;

      // Reset asserted during the second BUSY cycle discards the state.
      bus.ismc_valid_in = 1'b1;
      bus.state_in      = ALL7C;
      @(posedge clk);
      #1;
      bus.ismc_valid_in = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("mrst_valid", 128'(bus.ismc_valid_out), 128'd0);
      check("mrst_data", bus.state_out, 128'd0);
      check("mrst_ready", 128'(bus.ismc_ready_out), 128'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("mrst_quiet", 128'(bus.ismc_valid_out), 128'd0);
      end
      run_state("mrst_fresh", ALL63, ALL00);

      // Round trip through the encrypt model.
      for (int n = 0; n < 1000; n++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         run_state("rtrip", tb_enc(x), x);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
